mjr_scrub_ctrl: RTL and testbench
=================================

Name: mjr_scrub_ctrl

Overview:
- Controller plus storage for a bank of triplicated (TMR) words behind a single bitwise majority voter.
- Arbitrates one bank access per cycle between a host write port, a host read port, a fault-injection port and a periodic background scrubber.
- The scrubber walks every address, votes the three copies, writes back the voted value on any disagreement, and counts corrections.
- Sits beside the pipeline's TMR registers as the SEU maintenance engine for stored configuration/state.

Parameters:
- p_dataSize, 8: word width.
- p_addrSize, 3: address width; depth = 2**p_addrSize.
- p_scrubPeriod, 256: idle cycles between sweep starts; minimum 2.
- p_errCntSize, 16: width of the correction counter.

Ports:
- clk, input, 1: clock.
- rstN, input, 1: asynchronous active-low reset.
- wrReq, input, 1: host write request; level signal held until wrGnt.
- wrAddr, input, p_addrSize: write address.
- wrData, input, p_dataSize: written to all three copies.
- wrGnt, output, 1: combinational grant; the write happens at this clock edge.
- rdReq, input, 1: host read request; level signal held until rdGnt.
- rdAddr, input, p_addrSize: read address.
- rdGnt, output, 1: combinational read grant.
- rdValid, output, 1: registered; high one cycle after rdGnt.
- rdData, output, p_dataSize: voted word, valid with rdValid.
- rdErr, output, 1: copies disagreed for the read word; valid with rdValid.
- injEn, input, 1: fault-injection write to a single copy (test/debug).
- injCopy, input, 2: copy select, 0..2; a value of 3 is ignored.
- injAddr, input, p_addrSize: injection address.
- injData, input, p_dataSize: injection data.
- scrubEn, input, 1: enables the period timer and sweeps.
- scrubBusy, output, 1: high while the FSM is in SCRUB.
- scrubDone, output, 1: one-cycle pulse after the last address of a completed sweep.
- errCountClr, input, 1: synchronous clear of errCount.
- errCount, output, p_errCntSize: saturating count of scrub corrections.

Behaviour:
- Reset (rstN low, async):
  - All copies of all words = 0.
  - FSM = IDLE; timer, scrubAddr and errCount = 0.
  - rdValid, rdData, rdErr, scrubBusy and scrubDone = 0.
- Arbitration: one bank access per cycle, fixed priority injEn > wrReq > rdReq > scrub step.
  - Losing requesters hold their request.
  - A scrub step is taken only in a cycle with no granted host or injection access; scrubAddr holds otherwise.
- Write: on wrGnt, all 3 copies at wrAddr get wrData at the edge.
- Injection: only the selected copy at injAddr is written; no grant output; always wins.
- Read:
  - On rdGnt, the voter output and its error flag at rdAddr are registered.
  - Latency is 1 cycle: rdValid/rdData/rdErr appear the next cycle.
  - A read never repairs the word.
  - rdValid is low in any cycle without a prior-cycle grant.
- Voter: bitwise 2-of-3 majority; the error flag is the OR over bits of any disagreement. Three mutually different copies still give a bitwise result with error = 1.
- FSM IDLE:
  - The timer increments each cycle while scrubEn = 1.
  - When timer == p_scrubPeriod-1 and scrubEn = 1: timer returns to 0, scrubAddr = 0, next state SCRUB.
  - If scrubEn = 0, the timer holds at 0.
- FSM SCRUB:
  - Each scrub step votes at scrubAddr.
  - If the copies disagree: all 3 copies are written with the voted value at the same edge, and errCount increments.
  - scrubAddr then increments.
  - The step at the last address (all ones) returns the FSM to IDLE and pulses scrubDone in the following cycle.
- scrubEn dropped during SCRUB: the sweep aborts at the next edge. FSM goes to IDLE, no scrubDone, timer = 0, and already-made corrections are kept.
- errCount:
  - Saturates at all-ones.
  - errCountClr has priority over a same-cycle increment; the result is 0.
- Same-address events: accesses are serialized, so no read-modify-write race exists. A host write granted ahead of a scrub step at the same address is seen by that later step as clean.
- Mid-operation reset: takes effect immediately (async). Any pending read result is lost; rdValid = 0.

Decomposition:
- Package mjr_scrub_pkg:
  - Typedef for the FSM state enum (IDLE, SCRUB).
  - Typedef for the 2-bit copy select.
  - Access-source enum for the arbiter (INJ, WR, RD, SCRUB, NONE).
  - Localparam for depth.
- One sub-module: mjr_tmr_bank.
  - Contents: the three copy arrays, one write port with per-copy enables, one shared vote port instantiating the existing voter.
  - Arbiter, FSM, timer and counter stay in mjr_scrub_ctrl.

Test Plan:
1. Reset, then read addr 5 -> rdValid next cycle, rdData = 0x00, rdErr = 0, errCount = 0.
2. Write 0xA5 to addr 2, inject 0xFF into copy 1 at addr 2, read addr 2 -> rdData = 0xA5, rdErr = 1; repeat the read -> still rdErr = 1 (no repair on read).
3. p_scrubPeriod = 16, scrubEn = 1 after test 2 -> SCRUB entered after 16 cycles. Over the 8-step sweep errCount goes 0 -> 1, and scrubDone pulses exactly once. A subsequent read of addr 2 gives 0xA5 with rdErr = 0.
4. Hold wrReq and rdReq every cycle during a sweep -> wrGnt has priority, then rdGnt; scrubAddr frozen; the sweep finishes only after the requests drop.
5. Inject copy 0 = 0x0F, copy 1 = 0xF0, copy 2 = 0x3C at addr 7 -> read gives 0x3C, rdErr = 1; after a scrub sweep all copies = 0x3C.
6. Preload errCount to saturation (p_errCntSize = 2, 4 corrupted words) -> errCount = 3 and holds. Assert errCountClr in the same cycle as a correction -> errCount = 0. Drop scrubEn mid-sweep -> scrubBusy falls next cycle, no scrubDone.

Source files
------------

// File: rtl/mjr_scrub_pkg.sv
// Shared types for the TMR scrub controller and its storage bank.
package mjr_scrub_pkg;

  localparam int unsigned NUM_COPIES = 3;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SCRUB = 1'b1
  } state_e;

  typedef logic [1:0] copy_sel_t;

  // Winner of the single bank access slot in a cycle.
  typedef enum logic [2:0] {
    SRC_INJ   = 3'd0,
    SRC_WR    = 3'd1,
    SRC_RD    = 3'd2,
    SRC_SCRUB = 3'd3,
    SRC_NONE  = 3'd4
  } src_e;

  // One-hot copy write enable; select value 3 maps to no copy.
  function automatic logic [NUM_COPIES-1:0] copy_onehot(copy_sel_t sel);
    logic [NUM_COPIES-1:0] oh;
    oh = '0;
    case (sel)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mjr_tmr_bank.sv
// Triplicated word storage: three copy arrays, one write port with per-copy
// enables and one shared majority-vote read port.

// Bitwise 2-of-3 voter; err flags any bit where the copies disagree.
module mjr_tmr_voter #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  output logic [DW-1:0] vote_o,
  output logic          err_o
);
  assign vote_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign err_o  = |((a_i ^ b_i) | (a_i ^ c_i));
endmodule

module mjr_tmr_bank
  import mjr_scrub_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [NUM_COPIES-1:0] we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DW-1:0]         wdata_i,
  input  logic [AW-1:0]         vaddr_i,
  output logic [DW-1:0]         vote_o,
  output logic                  verr_o
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [NUM_COPIES-1:0][DW-1:0] rd_w;

  for (genvar gc = 0; gc < NUM_COPIES; gc++) begin : g_copy
    logic [DEPTH-1:0][DW-1:0] mem_q;

    // Copy storage, cleared to zero on reset.
    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)          mem_q <= '0;
      else if (we_i[gc])  mem_q[waddr_i] <= wdata_i;
    end

    assign rd_w[gc] = mem_q[vaddr_i];
  end

  mjr_tmr_voter #(.DW(DW)) u_voter (
    .a_i    (rd_w[0]),
    .b_i    (rd_w[1]),
    .c_i    (rd_w[2]),
    .vote_o (vote_o),
    .err_o  (verr_o)
  );

endmodule

// File: rtl/mjr_scrub_ctrl.sv
// SEU maintenance engine: arbitrates host write/read, fault injection and a
// periodic scrubber onto one TMR bank access per cycle.
module mjr_scrub_ctrl
  import mjr_scrub_pkg::*;
#(
  parameter int unsigned p_dataSize    = 8,
  parameter int unsigned p_addrSize    = 3,
  parameter int unsigned p_scrubPeriod = 256,
  parameter int unsigned p_errCntSize  = 16
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    wrReq,
  input  logic [p_addrSize-1:0]   wrAddr,
  input  logic [p_dataSize-1:0]   wrData,
  output logic                    wrGnt,
  input  logic                    rdReq,
  input  logic [p_addrSize-1:0]   rdAddr,
  output logic                    rdGnt,
  output logic                    rdValid,
  output logic [p_dataSize-1:0]   rdData,
  output logic                    rdErr,
  input  logic                    injEn,
  input  logic [1:0]              injCopy,
  input  logic [p_addrSize-1:0]   injAddr,
  input  logic [p_dataSize-1:0]   injData,
  input  logic                    scrubEn,
  output logic                    scrubBusy,
  output logic                    scrubDone,
  input  logic                    errCountClr,
  output logic [p_errCntSize-1:0] errCount
);
  localparam int unsigned TW = (p_scrubPeriod > 2) ? $clog2(p_scrubPeriod) : 1;
  localparam logic [TW-1:0] LAST_T = TW'(p_scrubPeriod - 1);

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [p_addrSize-1:0]   scrubAddr_q, scrubAddr_d;
  logic [p_errCntSize-1:0] errCount_q, errCount_d;
  logic                    rdValid_q, rdErr_q, scrubDone_q;
  logic [p_dataSize-1:0]   rdData_q;

  src_e                    src;
  logic                    scrubStep;
  logic                    sweepLast;
  logic [NUM_COPIES-1:0]   bankWe;
  logic [p_addrSize-1:0]   bankWaddr, bankVaddr;
  logic [p_dataSize-1:0]   bankWdata, vote;
  logic                    voteErr;

  // Fixed-priority arbiter: injection > write > read > scrub step.
  always_comb begin
    src = SRC_NONE;
    if (injEn)                                src = SRC_INJ;
    else if (wrReq)                           src = SRC_WR;
    else if (rdReq)                           src = SRC_RD;
    else if (state_q == ST_SCRUB && scrubEn)  src = SRC_SCRUB;
  end

  assign wrGnt     = (src == SRC_WR);
  assign rdGnt     = (src == SRC_RD);
  assign scrubStep = (src == SRC_SCRUB);
  assign sweepLast = scrubStep && (scrubAddr_q == '1);

  // Bank port steering; a scrub step rewrites all copies only on disagreement.
  always_comb begin
    bankWe    = '0;
    bankWaddr = wrAddr;
    bankWdata = wrData;
    bankVaddr = (src == SRC_RD) ? rdAddr : scrubAddr_q;
    case (src)
      SRC_INJ: begin
        bankWe    = copy_onehot(injCopy);
        bankWaddr = injAddr;
        bankWdata = injData;
      end
      SRC_WR:  bankWe = '1;
      SRC_SCRUB: begin
        bankWe    = {NUM_COPIES{voteErr}};
        bankWaddr = scrubAddr_q;
        bankWdata = vote;
      end
      default: ;
    endcase
  end

  mjr_tmr_bank #(.DW(p_dataSize), .AW(p_addrSize)) u_bank (
    .clk     (clk),
    .rstN    (rstN),
    .we_i    (bankWe),
    .waddr_i (bankWaddr),
    .wdata_i (bankWdata),
    .vaddr_i (bankVaddr),
    .vote_o  (vote),
    .verr_o  (voteErr)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: timer expiry starts a sweep; last step or disable ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (scrubEn && timer_q == LAST_T) state_d = ST_SCRUB;
      ST_SCRUB: if (!scrubEn || sweepLast)        state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    scrubBusy = (state_q == ST_SCRUB);
  end

  // Period timer, sweep address and saturating correction counter.
  always_comb begin
    timer_d     = timer_q;
    scrubAddr_d = scrubAddr_q;
    errCount_d  = errCount_q;
    if (state_q == ST_IDLE) begin
      if (!scrubEn) begin
        timer_d = '0;
      end else if (timer_q == LAST_T) begin
        timer_d     = '0;
        scrubAddr_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
      if (scrubStep) scrubAddr_d = scrubAddr_q + 1'b1;
    end
    if (errCountClr)                                       errCount_d = '0;
    else if (scrubStep && voteErr && errCount_q != '1)     errCount_d = errCount_q + 1'b1;
  end

  // Datapath registers: read result, done pulse, counters.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      timer_q     <= '0;
      scrubAddr_q <= '0;
      errCount_q  <= '0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
      rdErr_q     <= 1'b0;
      scrubDone_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      scrubAddr_q <= scrubAddr_d;
      errCount_q  <= errCount_d;
      rdValid_q   <= rdGnt;
      scrubDone_q <= sweepLast;
      if (rdGnt) begin
        rdData_q <= vote;
        rdErr_q  <= voteErr;
      end
    end
  end

  assign rdValid   = rdValid_q;
  assign rdData    = rdData_q;
  assign rdErr     = rdErr_q;
  assign scrubDone = scrubDone_q;
  assign errCount  = errCount_q;

endmodule

// File: tb/tb_mjr_scrub_ctrl.sv
// Directed bench for mjr_scrub_ctrl (8 words x 8 bits, 16-cycle period,
// 2-bit correction counter).
module tb_mjr_scrub_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       wrReq, rdReq, injEn, scrubEn, errCountClr;
  logic [2:0] wrAddr, rdAddr, injAddr;
  logic [7:0] wrData, injData, rdData;
  logic [1:0] injCopy, errCount;
  logic       wrGnt, rdGnt, rdValid, rdErr, scrubBusy, scrubDone;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mjr_scrub_ctrl #(
    .p_dataSize(8), .p_addrSize(3), .p_scrubPeriod(16), .p_errCntSize(2)
  ) dut (
    .clk(clk), .rstN(rstN),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrGnt(wrGnt),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdGnt(rdGnt),
    .rdValid(rdValid), .rdData(rdData), .rdErr(rdErr),
    .injEn(injEn), .injCopy(injCopy), .injAddr(injAddr), .injData(injData),
    .scrubEn(scrubEn), .scrubBusy(scrubBusy), .scrubDone(scrubDone),
    .errCountClr(errCountClr), .errCount(errCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    wrReq = 1'b1; wrAddr = a; wrData = d;
    tick();
    wrReq = 1'b0;
  endtask

  task automatic do_inject(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d);
    injEn = 1'b1; injCopy = c; injAddr = a; injData = d;
    tick();
    injEn = 1'b0;
  endtask

  // Single read; returns the registered result sampled one cycle later.
  task automatic do_read(input logic [2:0] a, output logic v, output logic [7:0] d, output logic e);
    rdReq = 1'b1; rdAddr = a;
    tick();
    rdReq = 1'b0;
    v = rdValid; d = rdData; e = rdErr;
  endtask

  // Enable scrubbing, run one full sweep, then disable. ok=0 on timeout.
  task automatic run_sweep(output bit ok);
    int n;
    ok = 1'b0;
    scrubEn = 1'b1;
    n = 0;
    while (!scrubBusy && n < 40) begin tick(); n++; end
    if (scrubBusy) begin
      n = 0;
      while (!scrubDone && n < 12) begin tick(); n++; end
      ok = scrubDone;
    end
    scrubEn = 1'b0;
  endtask

  task automatic test_reset();
    logic v, e; logic [7:0] d;
    rstN = 1'b0; wrReq = 0; rdReq = 0; injEn = 0; scrubEn = 0; errCountClr = 0;
    wrAddr = 0; rdAddr = 0; injAddr = 0; wrData = 0; injData = 0; injCopy = 0;
    #3;
    total++; if (rdValid !== 1'b0 || rdData !== 8'h00 || rdErr !== 1'b0) begin bad++;
      $display("FAIL reset_rd: got v=%b d=%h e=%b want 0/00/0", rdValid, rdData, rdErr); end
    total++; if (scrubBusy !== 1'b0 || scrubDone !== 1'b0 || errCount !== 2'd0) begin bad++;
      $display("FAIL reset_ctl: got busy=%b done=%b cnt=%0d want 0/0/0", scrubBusy, scrubDone, errCount); end
    @(negedge clk); rstN = 1'b1;
    tick();
    rdReq = 1'b1; rdAddr = 3'd5; #1;
    total++; if (rdGnt !== 1'b1) begin bad++; $display("FAIL reset_rdgnt: got %b want 1", rdGnt); end
    tick(); rdReq = 1'b0;
    v = rdValid; d = rdData; e = rdErr;
    total++; if (v !== 1'b1 || d !== 8'h00 || e !== 1'b0) begin bad++;
      $display("FAIL reset_read5: got v=%b d=%h e=%b want 1/00/0", v, d, e); end
    tick();
    total++; if (rdValid !== 1'b0) begin bad++; $display("FAIL rdvalid_idle: got %b want 0", rdValid); end
  endtask

  task automatic test_write_inject();
    logic v, e; logic [7:0] d;
    wrReq = 1'b1; wrAddr = 3'd2; wrData = 8'hA5; #1;
    total++; if (wrGnt !== 1'b1) begin bad++; $display("FAIL wrgnt: got %b want 1", wrGnt); end
    tick(); wrReq = 1'b0;
    do_inject(2'd1, 3'd2, 8'hFF);
    do_read(3'd2, v, d, e);
    total++; if (v !== 1'b1 || d !== 8'hA5 || e !== 1'b1) begin bad++;
      $display("FAIL inj_read1: got v=%b d=%h e=%b want 1/a5/1", v, d, e); end
    do_read(3'd2, v, d, e);
    total++; if (d !== 8'hA5 || e !== 1'b1) begin bad++;
      $display("FAIL inj_read2_norepair: got d=%h e=%b want a5/1", d, e); end
  endtask

  task automatic test_scrub_sweep();
    logic v, e; logic [7:0] d;
    int dones;
    scrubEn = 1'b1;
    repeat (15) tick();
    total++; if (scrubBusy !== 1'b0) begin bad++; $display("FAIL sweep_early: busy=%b want 0 after 15", scrubBusy); end
    tick();
    total++; if (scrubBusy !== 1'b1) begin bad++; $display("FAIL sweep_start: busy=%b want 1 after 16", scrubBusy); end
    dones = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (scrubDone) dones++;
      if (i == 8) begin
        total++; if (scrubBusy !== 1'b0 || scrubDone !== 1'b1) begin bad++;
          $display("FAIL sweep_end: busy=%b done=%b want 0/1", scrubBusy, scrubDone); end
      end
    end
    scrubEn = 1'b0;
    total++; if (dones !== 1) begin bad++; $display("FAIL sweep_done_cnt: got %0d want 1", dones); end
    total++; if (errCount !== 2'd1) begin bad++; $display("FAIL sweep_errcnt: got %0d want 1", errCount); end
    do_read(3'd2, v, d, e);
    total++; if (d !== 8'hA5 || e !== 1'b0) begin bad++;
      $display("FAIL sweep_repaired: got d=%h e=%b want a5/0", d, e); end
  endtask

  task automatic test_back_to_back();
    int n; bit busyOk, doneSeen;
    scrubEn = 1'b1;
    n = 0;
    while (!scrubBusy && n < 40) begin tick(); n++; end
    total++; if (scrubBusy !== 1'b1) begin bad++; $display("FAIL b2b_start: busy=%b want 1", scrubBusy); end
    wrReq = 1'b1; wrAddr = 3'd4; wrData = 8'h11;
    rdReq = 1'b1; rdAddr = 3'd4; #1;
    total++; if (wrGnt !== 1'b1 || rdGnt !== 1'b0) begin bad++;
      $display("FAIL b2b_prio_wr: got wr=%b rd=%b want 1/0", wrGnt, rdGnt); end
    injEn = 1'b1; injCopy = 2'd3; injAddr = 3'd4; injData = 8'hEE; #1;
    total++; if (wrGnt !== 1'b0 || rdGnt !== 1'b0) begin bad++;
      $display("FAIL b2b_prio_inj: got wr=%b rd=%b want 0/0", wrGnt, rdGnt); end
    busyOk = 1'b1; doneSeen = 1'b0;
    tick(); injEn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      busyOk &= scrubBusy; doneSeen |= scrubDone;
    end
    wrReq = 1'b0; #1;
    total++; if (rdGnt !== 1'b1) begin bad++; $display("FAIL b2b_rdgnt: got %b want 1", rdGnt); end
    tick();
    total++; if (rdValid !== 1'b1 || rdData !== 8'h11 || rdErr !== 1'b0) begin bad++;
      $display("FAIL b2b_read: got v=%b d=%h e=%b want 1/11/0", rdValid, rdData, rdErr); end
    for (int i = 0; i < 10; i++) begin
      tick();
      busyOk &= scrubBusy; doneSeen |= scrubDone;
    end
    rdReq = 1'b0;
    total++; if (!busyOk || doneSeen) begin bad++;
      $display("FAIL b2b_frozen: got busyHeld=%b doneSeen=%b want 1/0", busyOk, doneSeen); end
    n = 0;
    while (!scrubDone && n < 12) begin tick(); n++; end
    scrubEn = 1'b0;
    total++; if (scrubDone !== 1'b1 || n < 8) begin bad++;
      $display("FAIL b2b_finish: got done=%b after %0d want 1 after 8", scrubDone, n); end
    total++; if (errCount !== 2'd1) begin bad++; $display("FAIL b2b_errcnt: got %0d want 1", errCount); end
  endtask

  task automatic test_three_way();
    logic v, e; logic [7:0] d; bit ok;
    do_inject(2'd0, 3'd7, 8'h0F);
    do_inject(2'd1, 3'd7, 8'hF0);
    do_inject(2'd2, 3'd7, 8'h3C);
    do_read(3'd7, v, d, e);
    total++; if (d !== 8'h3C || e !== 1'b1) begin bad++;
      $display("FAIL tri_read: got d=%h e=%b want 3c/1", d, e); end
    run_sweep(ok);
    total++; if (!ok) begin bad++; $display("FAIL tri_sweep: timeout got 0 want 1"); end
    total++; if (errCount !== 2'd2) begin bad++; $display("FAIL tri_errcnt: got %0d want 2", errCount); end
    do_read(3'd7, v, d, e);
    total++; if (d !== 8'h3C || e !== 1'b0) begin bad++;
      $display("FAIL tri_repaired: got d=%h e=%b want 3c/0", d, e); end
  endtask

  task automatic test_errcount();
    logic v, e; logic [7:0] d; bit ok; int n, dones;
    do_inject(2'd0, 3'd0, 8'h55);
    do_inject(2'd0, 3'd1, 8'h55);
    do_inject(2'd0, 3'd3, 8'h55);
    do_inject(2'd0, 3'd6, 8'h55);
    run_sweep(ok);
    total++; if (!ok || errCount !== 2'd3) begin bad++;
      $display("FAIL sat_errcnt: got ok=%b cnt=%0d want 1/3", ok, errCount); end
    do_inject(2'd1, 3'd0, 8'h77);
    scrubEn = 1'b1;
    n = 0;
    while (!scrubBusy && n < 40) begin tick(); n++; end
    errCountClr = 1'b1;
    tick();
    errCountClr = 1'b0;
    total++; if (errCount !== 2'd0) begin bad++; $display("FAIL clr_prio: got %0d want 0", errCount); end
    tick(); tick();
    total++; if (scrubBusy !== 1'b1) begin bad++; $display("FAIL abort_pre: busy=%b want 1", scrubBusy); end
    scrubEn = 1'b0;
    tick();
    total++; if (scrubBusy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", scrubBusy); end
    dones = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (scrubDone) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_done: got %0d pulses want 0", dones); end
    do_read(3'd0, v, d, e);
    total++; if (d !== 8'h00 || e !== 1'b0 || errCount !== 2'd0) begin bad++;
      $display("FAIL abort_kept: got d=%h e=%b cnt=%0d want 00/0/0", d, e, errCount); end
  endtask

  task automatic test_mid_reset();
    logic v, e; logic [7:0] d;
    do_inject(2'd3, 3'd5, 8'hFF);
    do_read(3'd5, v, d, e);
    total++; if (d !== 8'h00 || e !== 1'b0) begin bad++;
      $display("FAIL inj_copy3: got d=%h e=%b want 00/0", d, e); end
    rdReq = 1'b1; rdAddr = 3'd2;
    tick();
    rdReq = 1'b0;
    total++; if (rdValid !== 1'b1 || rdData !== 8'hA5) begin bad++;
      $display("FAIL midrst_pre: got v=%b d=%h want 1/a5", rdValid, rdData); end
    rstN = 1'b0; #1;
    total++; if (rdValid !== 1'b0 || rdData !== 8'h00) begin bad++;
      $display("FAIL midrst_async: got v=%b d=%h want 0/00", rdValid, rdData); end
    @(negedge clk); rstN = 1'b1;
    tick();
    do_read(3'd2, v, d, e);
    total++; if (d !== 8'h00 || e !== 1'b0) begin bad++;
      $display("FAIL midrst_mem: got d=%h e=%b want 00/0", d, e); end
  endtask

  initial begin
    test_reset();
    test_write_inject();
    test_scrub_sweep();
    test_back_to_back();
    test_three_way();
    test_errcount();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
